// File: rtl/fir_err_monitor_pkg.sv
// Shared types and default sizes for the FIR error monitor
// and the filterfir benches that drive it.
package fir_err_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SUMW  = 32;
  localparam int DEF_NSAMP = 256;

endpackage

// File: rtl/fir_err_monitor_abs_diff.sv
// Combinational |a-b|: a + ~b + 1 through a Sklansky prefix
// carry tree; the carry-out selects a-b or its negation.
module abs_diff #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d
);

  localparam int LVLS = $clog2(WIDTH);

  logic [WIDTH-1:0] nb;
  logic [WIDTH-1:0] gg;
  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] gt;
  logic [WIDTH-1:0] pt;
  logic [WIDTH:0]   cy;
  logic [WIDTH-1:0] s;
  int               j;

  always_comb begin
    nb = ~b;
    gg = a & nb;
    pp = a ^ nb;
    gt = '0;
    pt = '0;
    j  = 0;
    for (int l = 0; l < LVLS; l++) begin
      gt = gg;
      pt = pp;
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 1) begin
          j     = ((i >> l) << l) - 1;
          gg[i] = gt[i] | (pt[i] & gt[j]);
          pp[i] = pt[i] & pt[j];
        end
      end
    end
    // carry-in of 1 completes the two's complement of b
    cy[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      cy[i+1] = gg[i] | pp[i];
    end
    s = (a ^ nb) ^ cy[WIDTH-1:0];
    d = cy[WIDTH] ? s : (~s + 1'b1);
  end

endmodule

// File: rtl/fir_err_monitor.sv
// Compares exact vs approximate FIR outputs over a fixed
// window: error count, saturating |err| sum and max |err|.
module fir_err_monitor
  import fir_err_monitor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NSAMP = DEF_NSAMP,
  parameter int SUMW  = DEF_SUMW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] exact,
  input  logic [WIDTH-1:0] approx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      sample_cnt,
  output logic [15:0]      err_cnt,
  output logic [SUMW-1:0]  sum_abs_err,
  output logic [WIDTH-1:0] max_err
);

  localparam logic [15:0]     NSAMP_C = 16'(NSAMP);
  localparam logic [SUMW-1:0] SUM_MAX = '1;

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             v0_q, v0_d;
  logic [WIDTH-1:0] d1_q, d1_d;
  logic             v1_q, v1_d;
  logic [15:0]      err_q, err_d;
  logic [SUMW-1:0]  sum_q, sum_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] diff;
  logic [SUMW:0]    sum_ext;
  logic             clr;
  logic             acc;

  abs_diff #(.WIDTH(WIDTH)) u_abs (
    .a (a_q),
    .b (b_q),
    .d (diff)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    v0_d    = 1'b0;
    d1_d    = diff;
    v1_d    = v0_q;
    err_d   = err_q;
    sum_d   = sum_q;
    max_d   = max_q;
    clr     = 1'b0;
    acc     = 1'b0;
    sum_ext = {1'b0, sum_q} + {{(SUMW+1-WIDTH){1'b0}}, d1_q};

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          clr     = 1'b1;
        end
      end
      RUN: begin
        if (cnt_q == NSAMP_C) begin
          state_d = DRAIN;
        end else if (in_valid) begin
          acc = 1'b1;
        end
      end
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase

    if (acc) begin
      cnt_d = cnt_q + 16'd1;
      a_d   = exact;
      b_d   = approx;
      v0_d  = 1'b1;
    end

    if (v1_q) begin
      err_d = err_q + {15'd0, d1_q != '0};
      sum_d = sum_ext[SUMW] ? SUM_MAX : sum_ext[SUMW-1:0];
      max_d = (d1_q > max_q) ? d1_q : max_q;
    end

    // a new window must not inherit anything in flight
    if (clr) begin
      cnt_d = '0;
      v0_d  = 1'b0;
      v1_d  = 1'b0;
      d1_d  = '0;
      err_d = '0;
      sum_d = '0;
      max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      v0_q    <= 1'b0;
      d1_q    <= '0;
      v1_q    <= 1'b0;
      err_q   <= '0;
      sum_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      v0_q    <= v0_d;
      d1_q    <= d1_d;
      v1_q    <= v1_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
      max_q   <= max_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign done        = (state_q == DONE);
  assign sample_cnt  = cnt_q;
  assign err_cnt     = err_q;
  assign sum_abs_err = sum_q;
  assign max_err     = max_q;

endmodule

// File: tb/tb_fir_err_monitor.sv
// Bench for fir_err_monitor: timestamped sample-list model
// checked every cycle, plus literal window results.
module tb_fir_err_monitor;

  localparam int WIDTH = 16;
  localparam int NSAMP = 4;
  localparam int SUMW  = 16;
  localparam longint SMAX = (longint'(1) << SUMW) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] exact = '0;
  logic [WIDTH-1:0] approx = '0;
  logic             busy;
  logic             done;
  logic [15:0]      sample_cnt;
  logic [15:0]      err_cnt;
  logic [SUMW-1:0]  sum_abs_err;
  logic [WIDTH-1:0] max_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fir_err_monitor #(
    .WIDTH (WIDTH),
    .NSAMP (NSAMP),
    .SUMW  (SUMW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .exact       (exact),
    .approx      (approx),
    .busy        (busy),
    .done        (done),
    .sample_cnt  (sample_cnt),
    .err_cnt     (err_cnt),
    .sum_abs_err (sum_abs_err),
    .max_err     (max_err)
  );

  // Model: the window is the list of accepted |err| values with
  // the edge number each was accepted on; metrics see a sample
  // two edges later.
  int  edge_n = 0;
  int  smp_d[$];
  int  smp_e[$];
  bit  active = 1'b0;

  function automatic bit m_done();
    if (!active || smp_d.size() != NSAMP) return 1'b0;
    return edge_n >= smp_e[NSAMP-1] + 2;
  endfunction

  function automatic bit m_busy();
    return active && !m_done();
  endfunction

  function automatic longint m_err();
    longint n = 0;
    foreach (smp_d[i]) if (smp_e[i] <= edge_n - 2 && smp_d[i] != 0) n++;
    return n;
  endfunction

  function automatic longint m_sum();
    longint s = 0;
    foreach (smp_d[i]) if (smp_e[i] <= edge_n - 2) s += smp_d[i];
    return (s > SMAX) ? SMAX : s;
  endfunction

  function automatic longint m_max();
    longint m = 0;
    foreach (smp_d[i]) if (smp_e[i] <= edge_n - 2 && smp_d[i] > m) m = smp_d[i];
    return m;
  endfunction

  always @(posedge clk) begin : model
    bit was_busy;
    int e, a;
    was_busy = m_busy();
    edge_n++;
    e = int'(exact);
    a = int'(approx);
    if (rst) begin
      active = 1'b0;
      smp_d.delete();
      smp_e.delete();
    end else if (start && !was_busy) begin
      active = 1'b1;
      smp_d.delete();
      smp_e.delete();
    end else if (active && smp_d.size() < NSAMP && in_valid) begin
      smp_d.push_back((e > a) ? e - a : a - e);
      smp_e.push_back(edge_n);
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (edge_n > 0) begin
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("done", 64'(done), 64'(m_done()));
      chk("sample_cnt", 64'(sample_cnt), 64'(smp_d.size()));
      chk("err_cnt", 64'(err_cnt), m_err());
      chk("sum_abs_err", 64'(sum_abs_err), m_sum());
      chk("max_err", 64'(max_err), m_max());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int e, input int a);
    in_valid = 1'b1;
    exact    = WIDTH'(e);
    approx   = WIDTH'(a);
    tick();
    in_valid = 1'b0;
    exact    = '0;
    approx   = '0;
  endtask

  task automatic idle_junk();
    exact  = 16'd999;
    approx = 16'd0;
    tick();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_done_in_time"}, 64'(done), 64'd1);
  endtask

  task automatic lit(input string tag, input int ec, input int s,
                     input int m, input int sc);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(ec));
    chk({tag, "_sum"}, 64'(sum_abs_err), 64'(s));
    chk({tag, "_max"}, 64'(max_err), 64'(m));
    chk({tag, "_sample_cnt"}, 64'(sample_cnt), 64'(sc));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with start held high: must be ignored
    rst   = 1'b1;
    start = 1'b1;
    tick();
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    lit("rst", 0, 0, 0, 0);

    // identical streams
    do_start();
    send(10, 10); send(20, 20); send(30, 30); send(40, 40);
    wait_done("ident");
    lit("ident", 0, 0, 0, 4);

    // mixed error, both directions
    do_start();
    send(100, 98); send(5, 9); send(7, 7); send(0, 0);
    wait_done("mixed");
    lit("mixed", 2, 6, 4, 4);
    do_start();
    send(98, 100); send(9, 5); send(7, 7); send(0, 0);
    wait_done("swap");
    lit("swap", 2, 6, 4, 4);

    // gapped valid: 1,0,1,0,1,1 then exact done timing
    do_start();
    send(3, 1); idle_junk();
    send(1, 3); idle_junk();
    send(10, 10);
    send(0, 8);
    chk("gap_done_k", 64'(done), 64'd0);
    tick();
    chk("gap_done_k1", 64'(done), 64'd0);
    tick();
    chk("gap_done_k2", 64'(done), 64'd1);
    lit("gap", 3, 12, 8, 4);
    send(100, 0); send(200, 0); send(300, 1);
    lit("gap_frozen", 3, 12, 8, 4);

    // saturation at 2^SUMW-1
    do_start();
    send(16'hFFFF, 0); send(16'hFFFF, 0);
    send(0, 16'hFFFF); send(16'hFFFF, 0);
    wait_done("sat");
    lit("sat", 4, 16'hFFFF, 16'hFFFF, 4);
    do_start();
    send(16'h8000, 0); send(0, 16'h7FFF); send(1, 0); send(0, 0);
    wait_done("sat_edge");
    lit("sat_edge", 3, 16'hFFFF, 16'h8000, 4);

    // abort mid-window, then a clean window with a busy start
    do_start();
    send(50, 0); send(60, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    lit("abort", 0, 0, 0, 0);
    do_start();
    send(1, 2);
    start = 1'b1;
    send(4, 1);
    start = 1'b0;
    send(0, 0); send(9, 9);
    wait_done("restart");
    lit("restart", 2, 4, 3, 4);

    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
